// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with valid/ready handshake, optional 2-entry skid,
// stall / flush-to-bubble control and saturating stall/bubble performance counters.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   head_data;
    logic [CTRL_W-1:0]   head_ctrl;
    logic [DATA_W-1:0]   skid_data;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic                in_ready_q;
    logic                accept;
    logic                emit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // With the skid entry, in_ready comes straight from a flop so out_ready never reaches it.
    assign in_ready  = (SKID != 0) ? in_ready_q : ((state == EMPTY) || out_ready);
    assign out_valid = (state != EMPTY);
    assign out_data  = head_data;
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign occupancy = 2'(state);

    assign accept = in_valid && in_ready && !stall && !flush;
    assign emit   = out_valid && out_ready && !stall && !flush;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (!stall) begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !emit && (SKID != 0)) state_nxt = FULL;
                    else if (emit && !accept)           state_nxt = EMPTY;
                end
                FULL:    if (emit) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            head_data  <= '0;
            head_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (!flush && !stall) begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            head_data <= in_data;
                            head_ctrl <= in_ctrl;
                        end
                    end
                    ONE: begin
                        // Simultaneous accept and emit replaces the head in place.
                        if (accept && emit) begin
                            head_data <= in_data;
                            head_ctrl <= in_ctrl;
                        end else if (accept) begin
                            skid_data <= in_data;
                            skid_ctrl <= in_ctrl;
                        end
                    end
                    FULL: begin
                        if (emit) begin
                            head_data <= skid_data;
                            head_ctrl <= skid_ctrl;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= sat_inc(stall_cnt);
            if (out_ready && !out_valid && !stall) bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed table, counter/reset sequences, and a random run
// checked against a queue-level model for both the skid and single-entry variants.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [11:0] in_ctrl;
    logic        stall;
    logic        flush;
    logic        out_ready;
    logic        clr_cnt;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [11:0] a_out_ctrl, b_out_ctrl;
    logic [1:0]  a_occ, b_occ;
    logic [3:0]  a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;

    int n_chk;
    int n_fail;

    function automatic logic [11:0] ctrl_of(input logic [31:0] d);
        return d[11:0] ^ d[23:12] ^ 12'h5A5;
    endfunction

    assign in_ctrl = ctrl_of(in_data);

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(12), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .occupancy(a_occ), .clr_cnt(clr_cnt),
        .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
    );

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(12), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .occupancy(b_occ), .clr_cnt(clr_cnt),
        .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        stl;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic [1:0]  occ;
    } vec_t;

    function automatic vec_t mkv(input logic iv, input logic [31:0] d, input logic ordy,
                                 input logic stl, input logic fl, input logic ov,
                                 input logic [31:0] od, input logic ir, input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.stl = stl; v.fl = fl;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        return v;
    endfunction

    // Reference model: each stage is an ordered list of at most two beats.
    typedef struct {
        logic [31:0] d;
        logic [11:0] c;
    } beat_t;

    beat_t mem [2][2];
    int    cnt [2];
    int    mst [2];
    int    mbb [2];

    function automatic logic model_ir(input int k);
        if (k == 0) return (cnt[k] < 2);
        return (cnt[k] == 0) || out_ready;
    endfunction

    task automatic check_model(input int k, input logic ir, input logic ov, input logic [31:0] od,
                               input logic [11:0] oc, input logic [1:0] occ,
                               input logic [3:0] sc, input logic [3:0] bc);
        chk($sformatf("rnd%0d_in_ready", k), 32'(ir), 32'(model_ir(k)));
        chk($sformatf("rnd%0d_out_valid", k), 32'(ov), 32'(cnt[k] > 0));
        chk($sformatf("rnd%0d_occupancy", k), 32'(occ), 32'(cnt[k]));
        if (cnt[k] > 0) begin
            chk($sformatf("rnd%0d_out_data", k), od, mem[k][0].d);
            chk($sformatf("rnd%0d_out_ctrl", k), 32'(oc), 32'(mem[k][0].c));
        end else begin
            chk($sformatf("rnd%0d_out_ctrl", k), 32'(oc), 32'd0);
        end
        chk($sformatf("rnd%0d_stall_cnt", k), 32'(sc), 32'(mst[k]));
        chk($sformatf("rnd%0d_bubble_cnt", k), 32'(bc), 32'(mbb[k]));
    endtask

    task automatic model_step(input int k);
        logic acc;
        logic emt;
        acc = in_valid && model_ir(k) && !stall && !flush;
        emt = (cnt[k] > 0) && out_ready && !stall && !flush;
        if (clr_cnt) begin
            mst[k] = 0;
            mbb[k] = 0;
        end else begin
            if (stall && mst[k] < 15) mst[k]++;
            if (out_ready && cnt[k] == 0 && !stall && mbb[k] < 15) mbb[k]++;
        end
        if (flush) begin
            cnt[k] = 0;
        end else begin
            if (emt) begin
                mem[k][0] = mem[k][1];
                cnt[k]--;
            end
            if (acc) begin
                mem[k][cnt[k]].d = in_data;
                mem[k][cnt[k]].c = in_ctrl;
                cnt[k]++;
            end
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    endtask

    vec_t vec [29];

    initial begin
        n_chk = 0;
        n_fail = 0;

        vec[0] = mkv(1, 32'h1, 1, 0, 0, 0, 32'h0, 1, 0);
        for (int i = 1; i < 8; i++) vec[i] = mkv(1, 32'(i + 1), 1, 0, 0, 1, 32'(i), 1, 1);
        vec[8]  = mkv(0, 32'h0,  1, 0, 0, 1, 32'h8,  1, 1);
        vec[9]  = mkv(0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0);
        vec[10] = mkv(1, 32'hA,  0, 0, 0, 0, 32'h0,  1, 0);
        vec[11] = mkv(1, 32'hB,  0, 0, 0, 1, 32'hA,  1, 1);
        vec[12] = mkv(0, 32'h0,  0, 0, 0, 1, 32'hA,  0, 2);
        vec[13] = mkv(0, 32'h0,  0, 0, 0, 1, 32'hA,  0, 2);
        vec[14] = mkv(0, 32'h0,  1, 0, 0, 1, 32'hA,  0, 2);
        vec[15] = mkv(0, 32'h0,  1, 0, 0, 1, 32'hB,  1, 1);
        vec[16] = mkv(0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0);
        vec[17] = mkv(1, 32'h11, 0, 0, 0, 0, 32'h0,  1, 0);
        vec[18] = mkv(1, 32'h12, 0, 0, 0, 1, 32'h11, 1, 1);
        vec[19] = mkv(1, 32'hC,  0, 0, 1, 1, 32'h11, 0, 2);
        vec[20] = mkv(0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0);
        vec[21] = mkv(1, 32'hD,  0, 0, 1, 0, 32'h0,  1, 0);
        vec[22] = mkv(0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0);
        vec[23] = mkv(1, 32'h5,  0, 0, 0, 0, 32'h0,  1, 0);
        for (int i = 24; i < 27; i++) vec[i] = mkv(1, 32'h77, 1, 1, 0, 1, 32'h5, 1, 1);
        vec[27] = mkv(0, 32'h0,  1, 0, 0, 1, 32'h5,  1, 1);
        vec[28] = mkv(0, 32'h0,  1, 0, 0, 0, 32'h0,  1, 0);

        // Reset values
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_out_ctrl", 32'(a_out_ctrl), 32'd0);
        chk("rst_occupancy", 32'(a_occ), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_stall_cnt", 32'(a_stall_cnt), 32'd0);
        chk("rst_bubble_cnt", 32'(a_bubble_cnt), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: streaming, backpressure, flush, stall
        for (int r = 0; r < 29; r++) begin
            in_valid = vec[r].iv; in_data = vec[r].d; out_ready = vec[r].ordy;
            stall = vec[r].stl; flush = vec[r].fl;
            #1;
            chk($sformatf("row%0d_out_valid", r), 32'(a_out_valid), 32'(vec[r].ov));
            chk($sformatf("row%0d_in_ready", r), 32'(a_in_ready), 32'(vec[r].ir));
            chk($sformatf("row%0d_occupancy", r), 32'(a_occ), 32'(vec[r].occ));
            if (vec[r].ov) begin
                chk($sformatf("row%0d_out_data", r), a_out_data, vec[r].od);
                chk($sformatf("row%0d_out_ctrl", r), 32'(a_out_ctrl), 32'(ctrl_of(vec[r].od)));
            end else begin
                chk($sformatf("row%0d_out_ctrl", r), 32'(a_out_ctrl), 32'd0);
            end
            @(negedge clk);
        end
        idle_inputs();

        // Counters: clear, stall count, flush+stall, bubble saturation, clear again
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        chk("cnt_clr_stall", 32'(a_stall_cnt), 32'd0);
        chk("cnt_clr_bubble", 32'(a_bubble_cnt), 32'd0);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        #1;
        chk("cnt_stall3", 32'(a_stall_cnt), 32'd3);
        stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        #1;
        chk("cnt_stall_flush", 32'(a_stall_cnt), 32'd4);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("cnt_bubble_sat", 32'(a_bubble_cnt), 32'd15);
        clr_cnt = 1'b1;
        @(negedge clk);
        #1;
        chk("cnt_bubble_clr", 32'(a_bubble_cnt), 32'd0);
        idle_inputs();

        // Asynchronous reset with two beats held
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h21;
        @(negedge clk);
        in_data = 32'h22;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("arst_pre_occupancy", 32'(a_occ), 32'd2);
        chk("arst_pre_in_ready", 32'(a_in_ready), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(a_out_valid), 32'd0);
        chk("arst_occupancy", 32'(a_occ), 32'd0);
        chk("arst_out_data", a_out_data, 32'd0);
        chk("arst_out_ctrl", 32'(a_out_ctrl), 32'd0);
        chk("arst_in_ready", 32'(a_in_ready), 32'd1);
        chk("arst_b_out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single-entry variant: streaming, then combinational in_ready under backpressure
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 8); in_data = 32'(i + 1); out_ready = 1'b1;
            #1;
            chk($sformatf("s0_stream%0d_in_ready", i), 32'(b_in_ready), 32'd1);
            chk($sformatf("s0_stream%0d_out_valid", i), 32'(b_out_valid), 32'(i > 0));
            if (i > 0) chk($sformatf("s0_stream%0d_out_data", i), b_out_data, 32'(i));
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'hB;
        #1;
        chk("s0_bp_in_ready_low", 32'(b_in_ready), 32'd0);
        chk("s0_bp_occupancy", 32'(b_occ), 32'd1);
        chk("s0_bp_out_data_a", b_out_data, 32'hA);
        out_ready = 1'b1;
        #1;
        chk("s0_bp_in_ready_comb", 32'(b_in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("s0_bp_out_valid_b", 32'(b_out_valid), 32'd1);
        chk("s0_bp_out_data_b", b_out_data, 32'hB);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("s0_bp_drained", 32'(b_out_valid), 32'd0);
        chk("s0_bp_in_ready_empty", 32'(b_in_ready), 32'd1);

        // Random run against the model, both variants
        idle_inputs();
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; mst[k] = 0; mbb[k] = 0;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            clr_cnt   = ($urandom_range(0, 59) == 0);
            #1;
            check_model(0, a_in_ready, a_out_valid, a_out_data, a_out_ctrl, a_occ, a_stall_cnt, a_bubble_cnt);
            check_model(1, b_in_ready, b_out_valid, b_out_data, b_out_ctrl, b_occ, b_stall_cnt, b_bubble_cnt);
            model_step(0);
            model_step(1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
